// File: rtl/bombe_pkg.sv
// bombe_pkg: constants shared by the bombe crib logic.
//   - ASCII bounds for upper/lower case letters and the case-folding offset.
//   - Sequencer state encoding.
package bombe_pkg;

   localparam logic [7:0] CHAR_A      = 8'h41;
   localparam logic [7:0] CHAR_Z      = 8'h5A;
   localparam logic [7:0] CHAR_LA     = 8'h61;
   localparam logic [7:0] CHAR_LZ     = 8'h7A;
   localparam logic [7:0] CASE_OFFSET = 8'h20;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_PLAY = 2'd1,
      ST_DONE = 2'd2
   } seq_state_e;

endpackage : bombe_pkg

// File: rtl/crib_letter_bank.sv
// crib_letter_bank: MAX_LEN x 8-bit letter register file.
//   clk_i    rising-edge clock
//   reset_i  synchronous, active-high; all entries to 'A'
//   clr_i    synchronous clear, all entries to 'A'
//   we_i     write enable for wdata_i at waddr_i
//   waddr_i  write address
//   wdata_i  write data
//   raddr_i  combinational read address (out-of-range reads return 'A')
//   rdata_o  read data
module crib_letter_bank
   import bombe_pkg::*;
#(
   parameter int unsigned MAX_LEN = 16,
   parameter int unsigned CNT_W   = 5
) (
   input  logic             clk_i,
   input  logic             reset_i,
   input  logic             clr_i,
   input  logic             we_i,
   input  logic [CNT_W-1:0] waddr_i,
   input  logic [7:0]       wdata_i,
   input  logic [CNT_W-1:0] raddr_i,
   output logic [7:0]       rdata_o
);

   logic [7:0] mem_q [MAX_LEN];

   always_ff @(posedge clk_i) begin
      if (reset_i || clr_i) begin
         for (int unsigned i = 0; i < MAX_LEN; i++) begin
            mem_q[i] <= CHAR_A;
         end
      end else if (we_i) begin
         for (int unsigned i = 0; i < MAX_LEN; i++) begin
            if (waddr_i == CNT_W'(i)) begin
               mem_q[i] <= wdata_i;
            end
         end
      end
   end

   // Decoded read mux keeps the address width independent of the array size.
   always_comb begin
      rdata_o = CHAR_A;
      for (int unsigned i = 0; i < MAX_LEN; i++) begin
         if (raddr_i == CNT_W'(i)) begin
            rdata_o = mem_q[i];
         end
      end
   end

endmodule : crib_letter_bank

// File: rtl/crib_sequencer.sv
// crib_sequencer: accepts crib letters over valid/ready, folds them to uppercase,
// stores them, and replays them in order on start.
//   clk, reset                 clock, synchronous active-high reset
//   in_valid/in_letter/in_ready  letter input handshake
//   clear, start               IDLE-only commands (clear wins)
//   out_valid/out_letter/out_ready/out_last  replay output handshake (registered)
//   len                        letters stored
//   busy                       high in PLAY and DONE
//   done                       one-cycle pulse after the final letter is taken
//   err_bad_char               one-cycle pulse after a non-letter was accepted
module crib_sequencer
   import bombe_pkg::*;
#(
   parameter int unsigned MAX_LEN = 16,
   parameter int unsigned CNT_W   = 5
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   input  logic [7:0]       in_letter,
   output logic             in_ready,
   input  logic             clear,
   input  logic             start,
   output logic             out_valid,
   output logic [7:0]       out_letter,
   input  logic             out_ready,
   output logic             out_last,
   output logic [CNT_W-1:0] len,
   output logic             busy,
   output logic             done,
   output logic             err_bad_char
);

   seq_state_e       state_q;
   logic [CNT_W-1:0] len_q, ptr_q;
   logic             out_valid_q, out_last_q, done_q, err_q;
   logic [7:0]       out_letter_q;

   logic             char_ok;
   logic [7:0]       norm_char;
   logic             accept;
   logic             clr_bank;
   logic [CNT_W-1:0] ptr_d;
   logic             last_d;
   logic [CNT_W-1:0] raddr;
   logic [7:0]       rdata;

   // Letter validation and case folding.
   always_comb begin
      char_ok   = 1'b0;
      norm_char = in_letter;
      if (in_letter >= CHAR_A && in_letter <= CHAR_Z) begin
         char_ok = 1'b1;
      end else if (in_letter >= CHAR_LA && in_letter <= CHAR_LZ) begin
         char_ok   = 1'b1;
         norm_char = in_letter - CASE_OFFSET;
      end
   end

   assign in_ready = (state_q == ST_IDLE) && (len_q < CNT_W'(MAX_LEN)) && !start && !clear;
   assign accept   = in_valid && in_ready;
   assign clr_bank = (state_q == ST_IDLE) && clear;

   assign ptr_d  = ptr_q + CNT_W'(1);
   assign last_d = (ptr_d == len_q - CNT_W'(1));
   // In IDLE the read port looks at entry 0 so start can load it directly.
   assign raddr  = (state_q == ST_PLAY) ? ptr_d : '0;

   crib_letter_bank #(
      .MAX_LEN (MAX_LEN),
      .CNT_W   (CNT_W)
   ) u_bank (
      .clk_i   (clk),
      .reset_i (reset),
      .clr_i   (clr_bank),
      .we_i    (accept && char_ok),
      .waddr_i (len_q),
      .wdata_i (norm_char),
      .raddr_i (raddr),
      .rdata_o (rdata)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         len_q        <= '0;
         ptr_q        <= '0;
         out_valid_q  <= 1'b0;
         out_letter_q <= CHAR_A;
         out_last_q   <= 1'b0;
         done_q       <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         done_q <= 1'b0;
         err_q  <= 1'b0;
         unique case (state_q)
            ST_IDLE: begin
               if (clear) begin
                  len_q <= '0;
               end else if (start && len_q != '0) begin
                  state_q      <= ST_PLAY;
                  ptr_q        <= '0;
                  out_valid_q  <= 1'b1;
                  out_letter_q <= rdata;
                  out_last_q   <= (len_q == CNT_W'(1));
               end else if (accept) begin
                  if (char_ok) begin
                     len_q <= len_q + CNT_W'(1);
                  end else begin
                     err_q <= 1'b1;
                  end
               end
            end
            ST_PLAY: begin
               // out_valid is always high in PLAY; outputs hold until taken.
               if (out_ready) begin
                  if (out_last_q) begin
                     state_q     <= ST_DONE;
                     out_valid_q <= 1'b0;
                     out_last_q  <= 1'b0;
                     done_q      <= 1'b1;
                  end else begin
                     ptr_q        <= ptr_d;
                     out_letter_q <= rdata;
                     out_last_q   <= last_d;
                  end
               end
            end
            ST_DONE: begin
               state_q <= ST_IDLE;
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign out_valid    = out_valid_q;
   assign out_letter   = out_letter_q;
   assign out_last     = out_last_q;
   assign len          = len_q;
   assign busy         = (state_q != ST_IDLE);
   assign done         = done_q;
   assign err_bad_char = err_q;

endmodule : crib_sequencer
